// File: rtl/venture_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encodings (idle / waiting for data / dropping a flushed response)
//   fifo_entry_t  : one buffered instruction (word + fetch address), 64 bits
//   NOP_INST      : reset value of buffered instruction words (addi x0, x0, 0)
package venture_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch stage's bus signals.
//   imem_*     : request/grant/response port to instruction memory
//   redirect_* : PC redirect from execute
//   inst_*     : valid/ready stream of (instruction, pc) to decode
// Modports: master = fetch stage, slave = memory/execute/decode environment.
interface inst_fetch_if;
  import venture_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetched (instruction, pc) entries.
//   clk, rst_n : clock, asynchronous active-low reset (entries reset to NOP / pc 0)
//   push_i     : write push_data_i at the tail
//   pop_i      : drop the head entry
//   flush_i    : empty the FIFO; overrides push and pop in the same cycle
//   count_o    : number of valid entries
//   head_o     : entry at the head (stale when empty)
module inst_fifo
  import venture_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fifo_entry_t              push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fifo_entry_t              head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fifo_entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q < CntW'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Keep the read pointer so the head output still shows the last entry.
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{inst: NOP_INST, pc: '0};
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word read at a time to instruction memory, buffers
// returned words in inst_fifo and streams (instruction, pc) pairs to decode. A redirect
// flushes the buffer and drops any in-flight response.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_io     : inst_fetch_if master (imem request/response, redirect, instruction stream)
module inst_fetch
  import venture_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus_io
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            redirect;
  logic            issue;
  logic            grant;
  logic            push;
  logic            pop;
  logic [CntW-1:0] count;
  fifo_entry_t     head;
  fifo_entry_t     push_data;

  assign redirect = bus_io.redirect_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic. A response arriving together with a redirect is already the one
  // being dropped, so nothing remains outstanding afterwards.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant) state_d = StWait;
      StWait: begin
        if (bus_io.imem_rvalid) state_d = StIdle;
        else if (redirect)      state_d = StDrop;
      end
      StDrop: if (bus_io.imem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic. rst_n gates the request so nothing is issued while reset is held.
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    unique case (state_q)
      StIdle:  issue = rst_n && (count < CntW'(DEPTH)) && !redirect;
      StWait:  push  = bus_io.imem_rvalid && !redirect;
      default: begin
        issue = 1'b0;
        push  = 1'b0;
      end
    endcase
  end

  assign grant = issue && bus_io.imem_gnt;
  assign pop   = bus_io.inst_valid && bus_io.inst_ready;

  // Fetch address and pending-request address.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    if (redirect) begin
      fetch_pc_d = {bus_io.redirect_pc[XLEN-1:2], 2'b00};
    end else if (grant) begin
      pend_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign push_data = '{inst: bus_io.imem_rdata, pc: pend_pc_q};

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      (head)
  );

  assign bus_io.imem_req   = issue;
  assign bus_io.imem_addr  = fetch_pc_q;
  assign bus_io.inst_valid = (count != '0);
  assign bus_io.inst       = head.inst;
  assign bus_io.inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic clk;
  logic rst_n;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  int n_total;
  int n_pass;

  function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic redir,
                              logic [31:0] rpc, logic ready, logic ereq, logic [31:0] eaddr,
                              logic evalid, logic [31:0] epc, logic [31:0] einst);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einst = einst;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] rpc, input logic ready);
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rdata;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = ready;
  endtask

  vec_t vecs [27];

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //            gnt rv rdata          rd rpc            rdy  req addr         vld pc            inst
    // streaming with 1-cycle memory, decode always ready
    vecs[0]  = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h0,        0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 1, 32'h1000_0000,  0, 32'h0,         1,   0, 32'h4,        0, 32'h0,        32'h0);
    vecs[2]  = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h4,        1, 32'h0,        32'h1000_0000);
    vecs[3]  = mk(1, 1, 32'h1000_0004,  0, 32'h0,         1,   0, 32'h8,        0, 32'h0,        32'h0);
    vecs[4]  = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h8,        1, 32'h4,        32'h1000_0004);
    vecs[5]  = mk(1, 1, 32'h1000_0008,  0, 32'h0,         1,   0, 32'hC,        0, 32'h0,        32'h0);
    // decode stalls: FIFO fills to two, request stops; one pop re-enables it
    vecs[6]  = mk(0, 0, 32'h0,          0, 32'h0,         0,   1, 32'hC,        1, 32'h8,        32'h1000_0008);
    vecs[7]  = mk(1, 0, 32'h0,          0, 32'h0,         0,   1, 32'hC,        1, 32'h8,        32'h1000_0008);
    vecs[8]  = mk(1, 1, 32'h1000_000C,  0, 32'h0,         0,   0, 32'h10,       1, 32'h8,        32'h1000_0008);
    vecs[9]  = mk(1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h10,       1, 32'h8,        32'h1000_0008);
    vecs[10] = mk(1, 0, 32'h0,          0, 32'h0,         1,   0, 32'h10,       1, 32'h8,        32'h1000_0008);
    vecs[11] = mk(1, 0, 32'h0,          0, 32'h0,         0,   1, 32'h10,       1, 32'hC,        32'h1000_000C);
    // redirect to 0x103 while waiting: flush, drop the response, refetch at 0x100
    vecs[12] = mk(0, 0, 32'h0,          1, 32'h103,       0,   0, 32'h14,       1, 32'hC,        32'h1000_000C);
    vecs[13] = mk(1, 0, 32'h0,          0, 32'h0,         0,   0, 32'h100,      0, 32'h0,        32'h0);
    vecs[14] = mk(1, 1, 32'hDEAD_BEEF,  0, 32'h0,         0,   0, 32'h100,      0, 32'h0,        32'h0);
    vecs[15] = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h100,      0, 32'h0,        32'h0);
    // redirect together with the response: no push, request at new PC next cycle
    vecs[16] = mk(0, 1, 32'h0000_0055,  1, 32'h200,       1,   0, 32'h104,      0, 32'h0,        32'h0);
    // grant withheld for five cycles: request and address stable
    vecs[17] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0);
    vecs[18] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0);
    vecs[19] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0);
    vecs[20] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0);
    vecs[21] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h200,      0, 32'h0,        32'h0);
    // redirect to the top word (low bits forced clear), then address wraps to 0
    vecs[22] = mk(1, 0, 32'h0,          1, 32'hFFFF_FFFF, 1,   0, 32'h200,      0, 32'h0,        32'h0);
    vecs[23] = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
    vecs[24] = mk(0, 1, 32'h0000_0077,  0, 32'h0,         1,   0, 32'h0,        0, 32'h0,        32'h0);
    vecs[25] = mk(0, 0, 32'h0,          0, 32'h0,         1,   1, 32'h0,        1, 32'hFFFF_FFFC, 32'h0000_0077);
    vecs[26] = mk(1, 0, 32'h0,          0, 32'h0,         1,   1, 32'h0,        0, 32'h0,        32'h0);

    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   {31'b0, bus.imem_req},   32'h0);
    check("rst_addr",  bus.imem_addr,           32'h0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("rst_inst",  bus.inst,                32'h0000_0013);
    check("rst_pc",    bus.inst_pc,             32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
      #1;
      check($sformatf("v%0d_req", i),   {31'b0, bus.imem_req},   {31'b0, vecs[i].ereq});
      check($sformatf("v%0d_addr", i),  bus.imem_addr,           vecs[i].eaddr);
      check($sformatf("v%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].evalid});
      if (vecs[i].evalid) begin
        check($sformatf("v%0d_pc", i),   bus.inst_pc, vecs[i].epc);
        check($sformatf("v%0d_inst", i), bus.inst,    vecs[i].einst);
      end
    end

    // Reset while waiting for a response, then the stale response arrives in IDLE.
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'b0, bus.imem_req},   32'h0);
    check("mid_rst_addr",  bus.imem_addr,           32'h0);
    check("mid_rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 32'h0000_0099, 1'b0, 32'h0, 1'b0);
    #1;
    check("post_rst_req",  {31'b0, bus.imem_req}, 32'h1);
    check("post_rst_addr", bus.imem_addr,         32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("stale_valid",   {31'b0, bus.inst_valid}, 32'h0);
    check("stale_req",     {31'b0, bus.imem_req},   32'h1);
    check("stale_addr",    bus.imem_addr,           32'h0);

    // Fill one entry, then redirect while decode pops it: flush wins.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1);
    #1;
    check("pop_flush_pre_valid", {31'b0, bus.inst_valid}, 32'h1);
    check("pop_flush_pre_inst",  bus.inst,                32'hCAFE_0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    check("pop_flush_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("pop_flush_req",   {31'b0, bus.imem_req},   32'h1);
    check("pop_flush_addr",  bus.imem_addr,           32'h0000_0040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
